// File: rtl/led_fader.sv
// led_fader: ramps each LED channel toward its on/off target one step per prescaler tick, PWM drive.
// Latency: level updates the cycle after step_tick; out/settled one register stage after level. No backpressure.
// Optional macro LED_FADER_GAMMA_EN selects a quadratic duty curve (level*level, upper half).
module led_fader #(
    parameter int CHANNELS  = 4,
    parameter int PWM_WIDTH = 8,
    parameter int DIV_WIDTH = 32,
    parameter int STEP_DIV  = 100_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic                settled
);

    localparam logic [PWM_WIDTH-1:0] MAX       = '1;
    localparam logic [DIV_WIDTH-1:0] STEP_LAST = DIV_WIDTH'(STEP_DIV - 1);

    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [PWM_WIDTH-1:0] level_q [CHANNELS];
    logic [PWM_WIDTH-1:0] level_d [CHANNELS];
    logic [PWM_WIDTH-1:0] duty    [CHANNELS];
    logic [CHANNELS-1:0]  out_q, out_d;
    logic                 settled_q, settled_d;
    logic                 step_tick;

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_WIDTH-1:0] prod [CHANNELS];
`endif

    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        step_tick  = (step_cnt_q == STEP_LAST);
        step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
        settled_d  = 1'b1;
        out_d      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level_d[i] = level_q[i];
            if (step_tick) begin
                if (in[i] && level_q[i] != MAX)
                    level_d[i] = level_q[i] + 1'b1;
                else if (!in[i] && level_q[i] != '0)
                    level_d[i] = level_q[i] - 1'b1;
            end
`ifdef LED_FADER_GAMMA_EN
            prod[i] = (2*PWM_WIDTH)'(level_q[i]) * (2*PWM_WIDTH)'(level_q[i]);
            duty[i] = PWM_WIDTH'(prod[i] >> PWM_WIDTH);
`else
            duty[i] = level_q[i];
`endif
            // Full-on is forced so MAX never shows the one-cycle gap of duty > pwm_cnt.
            out_d[i]  = (level_q[i] == MAX) | (duty[i] > pwm_cnt_q);
            settled_d = settled_d & (in[i] ? (level_q[i] == MAX) : (level_q[i] == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            out_q      <= '0;
            settled_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) level_q[i] <= '0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            out_q      <= out_d;
            settled_q  <= settled_d;
            for (int i = 0; i < CHANNELS; i++) level_q[i] <= level_d[i];
        end
    end

    assign out     = out_q;
    assign settled = settled_q;

endmodule
